ipbus_status_slave: RTL and testbench
=====================================

# ipbus_status_slave

IPbus read-only responder for the Rider status register file. It sits between the IPbus transactor and the status register bank and turns IPbus strobes into single-cycle acknowledged reads of the flattened status words. It latches trigger timestamp LSB/MSB coherently across two reads. It rejects writes and out-of-range addresses with an error acknowledge.

## Interface
Parameters:
- `N_REGS`, default 19: number of 32-bit status words present.
- `ADDR_WIDTH`, default 5: low address bits decoded; must satisfy 2^ADDR_WIDTH ≥ N_REGS.
- `TS_LSB_ADDR`, default 11: word index of timestamp LSB; its MSB is at `TS_LSB_ADDR+1`.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  user interface clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `status_bus`  in  N_REGS*32  word k at bits [32k+31:32k]; word 0 is firmware version.
- `ipb_strobe`  in  1  transaction request; held high until ack/err seen.
- `ipb_write`  in  1  1 = write request (always rejected).
- `ipb_addr`  in  32  word address.
- `ipb_wdata`  in  32  ignored.
- `ipb_rdata`  out  32  read data, valid in the ack cycle, held until next ack.
- `ipb_ack`  out  1  one-cycle pulse, successful read.
- `ipb_err`  out  1  one-cycle pulse, rejected transaction.
- `read_count`  out  32  number of successful reads since reset.
- `err_count`  out  16  number of error responses since reset, saturating.

## Operation
- FSM states: IDLE, DECODE, RESP, RELEASE.
- IDLE: on `ipb_strobe`=1, capture `ipb_addr` and `ipb_write`, then go to DECODE.
- DECODE: classify the transaction.
  - Error if `ipb_write`=1, or if `ipb_addr[31:ADDR_WIDTH]`≠0, or if `ipb_addr[ADDR_WIDTH-1:0]`≥N_REGS.
  - Otherwise select the data word into `rdata_q`. Go to RESP.
- RESP: drive `ipb_ack` or `ipb_err` for exactly one cycle.
  - On ack, `ipb_rdata`←`rdata_q` and `read_count`+1 (wraps at 2^32).
  - On err, `ipb_rdata`←0 and `err_count`+1, saturating at 0xFFFF.
  - Go to RELEASE.
- RELEASE: wait for `ipb_strobe`=0, then go to IDLE. A strobe still high is never treated as a new request.
- Timestamp coherence:
  - A successful read of `TS_LSB_ADDR` copies word `TS_LSB_ADDR+1` into `ts_shadow` in the same DECODE cycle and sets `shadow_valid`.
  - A read of `TS_LSB_ADDR+1` returns `ts_shadow` if `shadow_valid`=1, otherwise the live word. The read clears `shadow_valid`.
  - A second LSB read before the MSB read overwrites the shadow.
  - Reads of other addresses do not touch the shadow.
- Writes have no side effect on any register, counter or shadow; they only increment `err_count`.
- Reset mid-transaction: FSM goes to IDLE, no ack/err is issued for the aborted request. If the strobe is still high after reset releases, it starts a fresh transaction.

## Timing
- Reset values: `ipb_rdata`=0, `ipb_ack`=0, `ipb_err`=0, `read_count`=0, `err_count`=0, `shadow_valid`=0, FSM=IDLE.
- Latency: strobe first sampled high at edge 0 → DECODE at edge 1 → ack/err high after edge 2, low after edge 3.
- `status_bus` is sampled at the DECODE edge only. Later changes do not alter the returned word.
- Minimum transaction period: 4 cycles (3 in flight plus ≥1 strobe-low cycle).
- `ipb_ack` and `ipb_err` are never high together, and never high outside RESP.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold `reset`=0 with `status_bus` word0=0x40010203 → every output is 0. Release, read address 0 → ack at strobe+2, `ipb_rdata`=0x40010203, `read_count`=1.
- Sweep: read addresses 0..18 with word k=0xA5000000+k → each ack carries the matching value; `read_count`=19, `err_count`=0.
- Errors: write to address 3, then read address 19, then read address 0x20 → three `ipb_err` pulses, `ipb_rdata`=0, `err_count`=3, no ack.
- Coherence: timestamp words {11,12}={0xFFFFFFFF,0x00000123}; read 11, then change word 12 to 0x124, then read 12 → returns 0x123. A second read of 12 returns 0x124.
- Handshake: hold strobe high 10 cycles after one read → exactly one ack pulse. Assert reset during DECODE → no ack; after release, re-read succeeds normally.
- Saturation: force 65540 error transactions → `err_count` holds at 0xFFFF; `read_count` wrap at 2^32 checked with a preloaded counter.

Source files
------------

// File: rtl/ipbus_status_slave.sv
// Read-only IPbus responder for the Rider status register file.
// It returns acknowledged single-word reads and keeps the trigger timestamp LSB/MSB pair coherent.
module ipbus_status_slave #(
  parameter int          N_REGS          = 19,
  parameter int          ADDR_WIDTH      = 5,
  parameter int          TS_LSB_ADDR     = 11,
  parameter logic [31:0] READ_COUNT_INIT = 32'd0,
  parameter logic [15:0] ERR_COUNT_INIT  = 16'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REGS*32-1:0]   status_bus,
  input  logic                   ipb_strobe,
  input  logic                   ipb_write,
  input  logic [31:0]            ipb_addr,
  input  logic [31:0]            ipb_wdata,
  output logic [31:0]            ipb_rdata,
  output logic                   ipb_ack,
  output logic                   ipb_err,
  output logic [31:0]            read_count,
  output logic [15:0]            err_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [ADDR_WIDTH:0]   N_REGS_L   = (ADDR_WIDTH + 1)'(N_REGS);
  localparam logic [ADDR_WIDTH-1:0] TS_LSB_IDX = ADDR_WIDTH'(TS_LSB_ADDR);
  localparam logic [ADDR_WIDTH-1:0] TS_MSB_IDX = ADDR_WIDTH'(TS_LSB_ADDR + 1);

  logic [1:0]            state_reg, state_next;
  logic [31:0]           addr_reg;
  logic                  write_reg;
  logic [31:0]           rdata_q_reg;
  logic                  err_q_reg;
  logic [31:0]           ts_shadow_reg;
  logic                  shadow_valid_reg;

  logic [31:0]           status_word [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  upper_nz;
  logic                  in_range;
  logic                  is_err;
  logic [31:0]           sel_data;
  logic                  unused_wdata;

  // Unpopulated word slots read as zero so every decoded index is a defined array element.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_words
      if (gi < N_REGS) begin : g_live
        assign status_word[gi] = status_bus[gi*32 +: 32];
      end else begin : g_pad
        assign status_word[gi] = 32'd0;
      end
    end
  endgenerate

  assign unused_wdata = ^ipb_wdata;

  assign idx      = addr_reg[ADDR_WIDTH-1:0];
  assign upper_nz = |addr_reg[31:ADDR_WIDTH];
  assign in_range = ({1'b0, idx} < N_REGS_L);
  assign is_err   = write_reg | upper_nz | ~in_range;
  assign sel_data = (idx == TS_MSB_IDX && shadow_valid_reg) ? ts_shadow_reg : status_word[idx];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (ipb_strobe) state_next = S_DECODE;
      S_DECODE:  state_next = S_RESP;
      S_RESP:    state_next = S_RELEASE;
      S_RELEASE: if (!ipb_strobe) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      addr_reg         <= 32'd0;
      write_reg        <= 1'b0;
      rdata_q_reg      <= 32'd0;
      err_q_reg        <= 1'b0;
      ts_shadow_reg    <= 32'd0;
      shadow_valid_reg <= 1'b0;
      ipb_rdata        <= 32'd0;
      ipb_ack          <= 1'b0;
      ipb_err          <= 1'b0;
      read_count       <= READ_COUNT_INIT;
      err_count        <= ERR_COUNT_INIT;
    end else begin
      state_reg <= state_next;
      ipb_ack   <= 1'b0;
      ipb_err   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (ipb_strobe) begin
            addr_reg  <= ipb_addr;
            write_reg <= ipb_write;
          end
        end
        S_DECODE: begin
          err_q_reg   <= is_err;
          rdata_q_reg <= is_err ? 32'd0 : sel_data;
          // The MSB is captured in the same cycle as the LSB so the pair stays coherent.
          if (!is_err) begin
            if (idx == TS_LSB_IDX) begin
              ts_shadow_reg    <= status_word[TS_MSB_IDX];
              shadow_valid_reg <= 1'b1;
            end else if (idx == TS_MSB_IDX) begin
              shadow_valid_reg <= 1'b0;
            end
          end
        end
        S_RESP: begin
          if (err_q_reg) begin
            ipb_err   <= 1'b1;
            ipb_rdata <= 32'd0;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          end else begin
            ipb_ack    <= 1'b1;
            ipb_rdata  <= rdata_q_reg;
            read_count <= read_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipbus_status_slave.sv
// Scoreboard bench for ipbus_status_slave: the driver queues expected responses, a monitor checks them.
module tb_ipbus_status_slave;
  localparam int N_REGS = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [N_REGS*32-1:0] status_bus;
  logic                 ipb_strobe, ipb_write;
  logic [31:0]          ipb_addr, ipb_wdata;
  logic [31:0]          ipb_rdata, read_count;
  logic                 ipb_ack, ipb_err;
  logic [15:0]          err_count;
  logic [31:0]          sat_rdata, sat_read_count;
  logic                 sat_ack, sat_err;
  logic [15:0]          sat_err_count;

  ipbus_status_slave #(.N_REGS(N_REGS)) dut (
    .clk(clk), .reset(rst_n), .status_bus(status_bus),
    .ipb_strobe(ipb_strobe), .ipb_write(ipb_write), .ipb_addr(ipb_addr), .ipb_wdata(ipb_wdata),
    .ipb_rdata(ipb_rdata), .ipb_ack(ipb_ack), .ipb_err(ipb_err),
    .read_count(read_count), .err_count(err_count)
  );

  // Same stimulus, counters preloaded near their limits to reach wrap and saturation quickly.
  ipbus_status_slave #(.N_REGS(N_REGS), .READ_COUNT_INIT(32'hFFFF_FFFE), .ERR_COUNT_INIT(16'hFFFC)) u_sat (
    .clk(clk), .reset(rst_n), .status_bus(status_bus),
    .ipb_strobe(ipb_strobe), .ipb_write(ipb_write), .ipb_addr(ipb_addr), .ipb_wdata(ipb_wdata),
    .ipb_rdata(sat_rdata), .ipb_ack(sat_ack), .ipb_err(sat_err),
    .read_count(sat_read_count), .err_count(sat_err_count)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic set_word(input int k, input logic [31:0] v);
    status_bus[k*32 +: 32] = v;
  endtask

  // Issue one transaction, check its latency, optionally keep strobe high for extra cycles.
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic exp_err,
                        input logic [31:0] exp_data, input int hold);
    exp_t e;
    int   n;
    e.err  = exp_err;
    e.data = exp_data;
    exp_q.push_back(e);
    @(negedge clk);
    ipb_write  = wr;
    ipb_addr   = a;
    ipb_wdata  = 32'hDEAD_0000 | a;
    ipb_strobe = 1'b1;
    n = 0;
    while (n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (ipb_ack || ipb_err) break;
    end
    check("latency", 32'(n), 32'd3);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    ipb_strobe = 1'b0;
    ipb_write  = 1'b0;
  endtask

  // Monitor: every ack/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ipb_ack || ipb_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp actual ack=%0b err=%0b rdata=0x%08h required none",
                 ipb_ack, ipb_err, ipb_rdata);
      end else begin
        e = exp_q.pop_front();
        $display("resp addr=0x%08h ack=%0b err=%0b rdata=0x%08h", ipb_addr, ipb_ack, ipb_err, ipb_rdata);
        if ({ipb_ack, ipb_err, ipb_rdata} !== {~e.err, e.err, e.data}) begin
          failures++;
          $display("FAIL resp actual ack=%0b err=%0b rdata=0x%08h required ack=%0b err=%0b rdata=0x%08h",
                   ipb_ack, ipb_err, ipb_rdata, ~e.err, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    ipb_strobe = 1'b0;
    ipb_write  = 1'b0;
    ipb_addr   = 32'd0;
    ipb_wdata  = 32'd0;
    status_bus = '0;
    set_word(0, 32'h4001_0203);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", ipb_rdata, 32'd0);
    check("rst_ack", 32'(ipb_ack), 32'd0);
    check("rst_err", 32'(ipb_err), 32'd0);
    check("rst_read_count", read_count, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("sat_rst_read_count", sat_read_count, 32'hFFFF_FFFE);
    rst_n = 1'b1;

    do_txn(1'b0, 32'd0, 1'b0, 32'h4001_0203, 0);
    check("read_count_1", read_count, 32'd1);
    check("sat_read_count_max", sat_read_count, 32'hFFFF_FFFF);

    for (int k = 0; k < N_REGS; k++) set_word(k, 32'hA500_0000 + 32'(k));
    for (int k = 0; k < N_REGS; k++) do_txn(1'b0, 32'(k), 1'b0, 32'hA500_0000 + 32'(k), 0);
    check("sweep_read_count", read_count, 32'd20);
    check("sweep_err_count", 32'(err_count), 32'd0);
    check("sat_read_count_wrap", sat_read_count, 32'd18);

    do_txn(1'b1, 32'd3, 1'b1, 32'd0, 0);
    do_txn(1'b0, 32'd19, 1'b1, 32'd0, 0);
    do_txn(1'b0, 32'h20, 1'b1, 32'd0, 0);
    check("err_count_3", 32'(err_count), 32'd3);
    check("err_read_count", read_count, 32'd20);
    check("err_rdata", ipb_rdata, 32'd0);
    check("sat_err_count_max", 32'(sat_err_count), 32'h0000_FFFF);
    do_txn(1'b1, 32'd0, 1'b1, 32'd0, 0);
    check("err_count_4", 32'(err_count), 32'd4);
    check("sat_err_count_hold", 32'(sat_err_count), 32'h0000_FFFF);

    set_word(11, 32'hFFFF_FFFF);
    set_word(12, 32'h0000_0123);
    do_txn(1'b0, 32'd11, 1'b0, 32'hFFFF_FFFF, 0);
    set_word(12, 32'h0000_0124);
    do_txn(1'b0, 32'd12, 1'b0, 32'h0000_0123, 0);
    do_txn(1'b0, 32'd12, 1'b0, 32'h0000_0124, 0);
    check("coh_read_count", read_count, 32'd23);

    do_txn(1'b0, 32'd5, 1'b0, 32'hA500_0005, 10);
    check("hold_read_count", read_count, 32'd24);
    check("hold_rdata", ipb_rdata, 32'hA500_0005);

    // Abort a read while it is in DECODE; no response may appear for it.
    @(negedge clk);
    ipb_addr   = 32'd0;
    ipb_write  = 1'b0;
    ipb_strobe = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    ipb_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_read_count", read_count, 32'd0);
    check("abort_err_count", 32'(err_count), 32'd0);
    check("abort_rdata", ipb_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'd0, 1'b0, 32'hA500_0000, 0);
    check("post_reset_read_count", read_count, 32'd1);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
